// File: rtl/fir_coef_loader_pkg.sv
// Shared definitions for the FIR coefficient loader and its bank.
package fir_coef_loader_pkg;

    // Width of one tap slot on the packed coefs bus.
    localparam int unsigned COEF_SLOT = 32;

    // Loader FSM states; encodings match the FIR block's shared header.
    typedef enum logic {
        StLoad   = 1'b0,
        StCommit = 1'b1
    } state_e;

    // Bit offset of a tap's slot on the packed bus; tap 0 sits in the top slot.
    function automatic int unsigned slot_lsb(input int unsigned tap, input int unsigned taps);
        return (taps - 1 - tap) * COEF_SLOT;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient register bank with sign-extending bus pack.
module fir_coef_bank
    import fir_coef_loader_pkg::*;
#(
    parameter int unsigned CWIDTH = 16,
    parameter int unsigned TAPS   = 8,
    parameter int unsigned IDXW   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en_i,
    input  logic [IDXW-1:0]           wr_idx_i,
    input  logic [CWIDTH-1:0]         wr_data_i,
    input  logic                      copy_i,
    output logic [TAPS*COEF_SLOT-1:0] coefs_o
);

    logic [CWIDTH-1:0] shadow_q [TAPS];
    logic [CWIDTH-1:0] active_q [TAPS];

    // Shadow bank: indexed single-word write from the load stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            for (int i = 0; i < TAPS; i++) begin
                if (wr_idx_i == IDXW'(i)) begin
                    shadow_q[i] <= wr_data_i;
                end
            end
        end
    end

    // Active bank: whole-set copy so the filter never sees a partial update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                active_q[i] <= '0;
            end
        end else if (copy_i) begin
            for (int i = 0; i < TAPS; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    // Pack each active tap into its slot, sign-extended to the slot width.
    for (genvar g = 0; g < TAPS; g++) begin : g_pack
        assign coefs_o[slot_lsb(g, TAPS) +: COEF_SLOT] = COEF_SLOT'($signed(active_q[g]));
    end

endmodule

// File: rtl/fir_coef_loader.sv
// Serial-to-parallel FIR coefficient loader with atomic shadow->active swap.
module fir_coef_loader
    import fir_coef_loader_pkg::*;
#(
    parameter int unsigned CWIDTH = 16,
    parameter int unsigned TAPS   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [CWIDTH-1:0]            s_data,
    input  logic                         s_last,
    input  logic                         swap_en,
    output logic [TAPS*COEF_SLOT-1:0]    coefs,
    output logic                         coef_ok,
    output logic                         swapped,
    output logic                         err,
    output logic [$clog2(TAPS+1)-1:0]    load_cnt
);

    localparam int unsigned CNTW = $clog2(TAPS + 1);
    localparam logic [CNTW-1:0] LastIdx = CNTW'(TAPS - 1);

    if (CWIDTH > COEF_SLOT || CWIDTH < 1) begin : g_cwidth_chk
        $error("fir_coef_loader: CWIDTH must be 1..32");
    end
    if (TAPS < 2) begin : g_taps_chk
        $error("fir_coef_loader: TAPS must be >= 2");
    end

    state_e          state_q;
    logic [CNTW-1:0] load_cnt_q;
    logic            coef_ok_q;
    logic            swapped_q;
    logic            err_q;
    logic            beat;
    logic            do_swap;

    // Ready is gated by reset so nothing is accepted while rst_n is low.
    always_comb begin
        s_ready = (state_q == StLoad) && rst_n;
        beat    = s_valid && s_ready;
        do_swap = (state_q == StCommit) && swap_en;
    end

    // Loader FSM, word counter and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StLoad;
            load_cnt_q <= '0;
            coef_ok_q  <= 1'b0;
            swapped_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            swapped_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                StLoad: begin
                    if (beat) begin
                        if (load_cnt_q == LastIdx) begin
                            if (s_last) begin
                                // Counter parks at TAPS while waiting for the swap.
                                state_q    <= StCommit;
                                load_cnt_q <= load_cnt_q + CNTW'(1);
                            end else begin
                                err_q      <= 1'b1;
                                load_cnt_q <= '0;
                            end
                        end else if (s_last) begin
                            err_q      <= 1'b1;
                            load_cnt_q <= '0;
                        end else begin
                            load_cnt_q <= load_cnt_q + CNTW'(1);
                        end
                    end
                end
                StCommit: begin
                    if (swap_en) begin
                        state_q    <= StLoad;
                        load_cnt_q <= '0;
                        coef_ok_q  <= 1'b1;
                        swapped_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= StLoad;
                    load_cnt_q <= '0;
                end
            endcase
        end
    end

    fir_coef_bank #(
        .CWIDTH (CWIDTH),
        .TAPS   (TAPS),
        .IDXW   (CNTW)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (beat),
        .wr_idx_i  (load_cnt_q),
        .wr_data_i (s_data),
        .copy_i    (do_swap),
        .coefs_o   (coefs)
    );

    // Registered status outputs.
    always_comb begin
        coef_ok  = coef_ok_q;
        swapped  = swapped_q;
        err      = err_q;
        load_cnt = load_cnt_q;
    end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Self-checking bench for fir_coef_loader: set-level model plus directed cases.
module tb_fir_coef_loader;

    localparam int unsigned CWIDTH = 16;
    localparam int unsigned TAPS   = 8;
    localparam int unsigned CNTW   = $clog2(TAPS + 1);
    localparam int unsigned BUSW   = TAPS * 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic              swap_en = 1'b0;
    logic [CWIDTH-1:0] s_data = '0;
    logic              s_ready;
    logic [BUSW-1:0]   coefs;
    logic              coef_ok;
    logic              swapped;
    logic              err;
    logic [CNTW-1:0]   load_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    fir_coef_loader #(
        .CWIDTH (CWIDTH),
        .TAPS   (TAPS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .swap_en  (swap_en),
        .coefs    (coefs),
        .coef_ok  (coef_ok),
        .swapped  (swapped),
        .err      (err),
        .load_cnt (load_cnt)
    );

    always #5 clk = ~clk;

    // Set-level model: words collected in a queue, a set becomes visible on swap.
    logic [CWIDTH-1:0] m_q [$];
    logic [31:0]       m_coefs [TAPS];
    bit                m_waiting = 1'b0;
    bit                m_ok = 1'b0;
    bit                m_swapped = 1'b0;
    bit                m_err = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            for (int i = 0; i < TAPS; i++) m_coefs[i] = 32'h0;
            m_waiting = 1'b0;
            m_ok      = 1'b0;
            m_swapped = 1'b0;
            m_err     = 1'b0;
        end else begin
            m_swapped = 1'b0;
            m_err     = 1'b0;
            if (m_waiting) begin
                if (swap_en) begin
                    for (int i = 0; i < TAPS; i++) m_coefs[i] = 32'($signed(m_q[i]));
                    m_q.delete();
                    m_waiting = 1'b0;
                    m_ok      = 1'b1;
                    m_swapped = 1'b1;
                end
            end else if (s_valid) begin
                m_q.push_back(s_data);
                if (s_last && m_q.size() == TAPS) begin
                    m_waiting = 1'b1;
                end else if (s_last || m_q.size() == TAPS) begin
                    m_err = 1'b1;
                    m_q.delete();
                end
            end
        end
    end

    function automatic logic [BUSW-1:0] model_bus();
        logic [BUSW-1:0] b = '0;
        for (int i = 0; i < TAPS; i++) b[(TAPS - 1 - i) * 32 +: 32] = m_coefs[i];
        return b;
    endfunction

    task automatic chk_bus(input string nm, input logic [BUSW-1:0] act,
                           input logic [BUSW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk_cnt(input string nm, input logic [CNTW-1:0] act,
                           input logic [CNTW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk1("m_s_ready", s_ready, logic'(!m_waiting && rst_n));
            chk_bus("m_coefs", coefs, model_bus());
            chk1("m_coef_ok", coef_ok, logic'(m_ok));
            chk1("m_swapped", swapped, logic'(m_swapped));
            chk1("m_err", err, logic'(m_err));
            chk_cnt("m_load_cnt", load_cnt, CNTW'(m_q.size()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat: optional idle gap, then hold valid until accepted (bounded).
    task automatic send(input logic [CWIDTH-1:0] d, input logic last, input int gap);
        int n = 0;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        chk1("send_ready", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    logic [CWIDTH-1:0] set3 [TAPS] = '{16'h0010, 16'h0020, 16'h0030, 16'hFFFE,
                                       16'h0050, 16'h8000, 16'h0070, 16'h7FFF};
    logic [BUSW-1:0] bus3;

    initial begin
        bus3 = {32'h00000010, 32'h00000020, 32'h00000030, 32'hFFFFFFFE,
                32'h00000050, 32'hFFFF8000, 32'h00000070, 32'h00007FFF};

        // Reset held three cycles.
        @(posedge clk);
        cmp_en = 1'b1;
        #1;
        repeat (3) begin
            chk_bus("rst_coefs", coefs, '0);
            chk1("rst_coef_ok", coef_ok, 1'b0);
            chk1("rst_s_ready", s_ready, 1'b0);
            tick();
        end
        rst_n = 1'b1;
        tick();
        chk1("rel_s_ready", s_ready, 1'b1);
        chk_cnt("rel_load_cnt", load_cnt, '0);

        // Nominal set 1..8 with immediate swap.
        swap_en = 1'b1;
        for (int i = 0; i < TAPS; i++) send(CWIDTH'(i + 1), i == TAPS - 1, 0);
        chk1("t2_commit_ready", s_ready, 1'b0);
        chk1("t2_no_swap_yet", swapped, 1'b0);
        chk_cnt("t2_cnt_taps", load_cnt, CNTW'(TAPS));
        tick();
        chk1("t2_swapped", swapped, 1'b1);
        chk32("t2_tap0", coefs[255:224], 32'h00000001);
        chk32("t2_tap7", coefs[31:0], 32'h00000008);
        chk1("t2_ready_back", s_ready, 1'b1);
        chk1("t2_coef_ok", coef_ok, 1'b1);
        tick();
        chk1("t2_pulse_end", swapped, 1'b0);

        // Sign extension with valid gaps.
        for (int i = 0; i < TAPS; i++) send(set3[i], i == TAPS - 1, i % 3);
        tick();
        chk32("t3_slot3", coefs[159:128], 32'hFFFFFFFE);
        chk32("t3_slot5", coefs[95:64], 32'hFFFF8000);
        chk_bus("t3_bus", coefs, bus3);

        // Completed set held by swap_en=0.
        swap_en = 1'b0;
        for (int i = 0; i < TAPS; i++) send(CWIDTH'(100 + i), i == TAPS - 1, 0);
        repeat (10) begin
            chk1("t4_hold_ready", s_ready, 1'b0);
            chk1("t4_hold_noswap", swapped, 1'b0);
            chk_bus("t4_hold_coefs", coefs, bus3);
            tick();
        end
        swap_en = 1'b1;
        tick();
        chk1("t4_swapped", swapped, 1'b1);
        chk32("t4_tap0", coefs[255:224], 32'd100);
        chk32("t4_tap7", coefs[31:0], 32'd107);

        // Short set terminated early, then an over-long set.
        for (int i = 0; i < 5; i++) send(CWIDTH'(i + 1), i == 4, 0);
        chk1("t5_short_err", err, 1'b1);
        chk_cnt("t5_short_cnt", load_cnt, '0);
        chk32("t5_short_coefs", coefs[255:224], 32'd100);
        for (int i = 0; i < TAPS; i++) send(CWIDTH'(50 + i), 1'b0, 0);
        chk1("t5_long_err", err, 1'b1);
        chk1("t5_long_noswap", swapped, 1'b0);
        chk_cnt("t5_long_cnt", load_cnt, '0);
        tick();
        chk1("t5_err_pulse_end", err, 1'b0);
        for (int i = 0; i < TAPS; i++) send(CWIDTH'(200 + i), i == TAPS - 1, 0);
        tick();
        chk1("t5_clean_swapped", swapped, 1'b1);
        chk32("t5_clean_tap0", coefs[255:224], 32'd200);
        chk32("t5_clean_tap7", coefs[31:0], 32'd207);

        // Reset in the middle of a load.
        for (int i = 0; i < 4; i++) send(CWIDTH'(9), 1'b0, 0);
        rst_n = 1'b0;
        tick();
        chk_bus("t6_rst_coefs", coefs, '0);
        chk_cnt("t6_rst_cnt", load_cnt, '0);
        chk1("t6_rst_coef_ok", coef_ok, 1'b0);
        chk1("t6_rst_ready", s_ready, 1'b0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < TAPS; i++) send(CWIDTH'(300 + i), i == TAPS - 1, 0);
        tick();
        chk1("t6_coef_ok", coef_ok, 1'b1);
        chk32("t6_tap0", coefs[255:224], 32'd300);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d",
                 checks, errors);
        $fatal(1, "timeout");
    end

endmodule
